// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder.
// Pure declarations: no latency and no handshake of their own.
// Holds the slice width, the controller state encoding and the overflow rule.
package cla_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cla_seq_state_t;

    // Overflow occurs when both addends share a sign that the result does not.
    function automatic logic ovf_rule(input logic a_msb, input logic b_msb, input logic sum_msb);
        return (a_msb == b_msb) && (sum_msb != a_msb);
    endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// 4-bit carry-lookahead adder slice.
// Purely combinational: zero cycles of latency.
// No handshake, so it never applies backpressure.
module carry_lookahead_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = A & B;
    assign p = A ^ B;

    // All carries come straight from generate/propagate terms, with no ripple.
    assign c[0] = Cin;
    assign c[1] = g[0] | (p[0] & Cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & Cin);

    assign Sum  = p ^ c[3:0];
    assign Cout = c[4];

endmodule

// File: rtl/cla_seq_adder.sv
// WIDTH-bit add/subtract that reuses one 4-bit CLA slice, one nibble per clock, LSB nibble first.
// Latency: out_valid rises WIDTH/4 edges after the accepting edge.
// Backpressure: the result holds in DONE until out_ready; in_ready is high only in IDLE.
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if (((WIDTH % SLICE_W) != 0) || (WIDTH < SLICE_W)) begin : g_bad_width
        $error("cla_seq_adder: WIDTH must be a positive multiple of 4");
    end

    cla_seq_state_t   state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               last_slice;

    assign slice_a    = a_q[idx_q*SLICE_W +: SLICE_W];
    assign slice_b    = b_q[idx_q*SLICE_W +: SLICE_W];
    assign last_slice = (idx_q == IDX_W'(NSLICE - 1));

    carry_lookahead_adder u_slice (
        .A    (slice_a),
        .B    (slice_b),
        .Cin  (carry_q),
        .Sum  (slice_sum),
        .Cout (slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is A + ~B + 1, so cin is ignored in that mode.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = sub ? ~b[WIDTH-1] : b[WIDTH-1];
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*SLICE_W +: SLICE_W] = slice_sum;
                carry_d = slice_cout;
                if (last_slice) begin
                    cout_d  = slice_cout;
                    ovf_d   = ovf_rule(a_msb_q, b_msb_q, slice_sum[SLICE_W-1]);
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder (WIDTH=16) with hand-computed expected results.
module tb_cla_seq_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    int checks = 0;
    int errors = 0;

    cla_seq_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation with out_ready high and check latency and result.
    task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic vcin, input logic vsub, input logic [15:0] esum,
                          input logic ecout, input logic eovf);
        int n;
        a = va; b = vb; cin = vcin; sub = vsub; in_valid = 1'b1; out_ready = 1'b1;
        check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd4);
        check({tag, "_sum"}, 32'(sum), 32'(esum));
        check({tag, "_cout"}, 32'(cout), 32'(ecout));
        check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
        check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        tick();
        check({tag, "_back_idle"}, 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", 32'({ovf, cout, sum}), 32'd0);
        #11 rst_n = 1'b1;
        tick();

        run_op("add_basic", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
        run_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_cin_ovf", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_op("sub_zero", 16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Backpressure: result must hold and the pending request must wait.
        a = 16'h0001; b = 16'h0002; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        a = 16'h0010; b = 16'h0020;
        for (int i = 0; i < 4; i++) tick();
        check("bp_reached_done", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold", 32'({out_valid, in_ready, ovf, cout, sum}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 16'h0003}));
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_idle", 32'({busy, out_valid, in_ready}), 32'b001);
        tick();
        in_valid = 1'b0;
        check("bp_pending_accepted", 32'({busy, in_ready}), 32'b10);
        for (int i = 0; i < 3; i++) tick();
        check("bp_second_not_yet", 32'(out_valid), 32'd0);
        tick();
        check("bp_second_valid", 32'(out_valid), 32'd1);
        check("bp_second_sum", 32'(sum), 32'h0030);
        tick();

        // Asynchronous reset between edges after two slices.
        a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_sum", 32'(sum), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        #13 rst_n = 1'b1;
        tick();
        check("arst_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("arst_no_result", 32'(seen), 32'd0);

        // Operand changes after acceptance must not affect the result.
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 16'($urandom); b = 16'($urandom); sub = ~sub; cin = ~cin;
            tick();
        end
        check("iso_valid", 32'(out_valid), 32'd1);
        check("iso_sum", 32'(sum), 32'h0100);
        check("iso_cout", 32'(cout), 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cla_seq_adder.md
Name: cla_seq_adder

Overview:
- Sequencing controller that performs WIDTH-bit add/subtract by time-sharing one 4-bit carry-lookahead adder slice, one nibble per clock, LSB nibble first.
- Registered carry links successive slices.
- Sits between a requester (valid/ready operand port) and a consumer (valid/ready result port).
- Used where area matters more than latency.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4 (elaboration error otherwise).
- NSLICE, WIDTH/4, derived (localparam), number of slice passes per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add mode only).
- sub  input  1  1 = A - B, 0 = A + B + cin.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB (subtract: 1 = no borrow).
- ovf  output  1  signed two's-complement overflow.
- busy  output  1  state != IDLE.

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low (rst_n); assertion immediately forces state IDLE, idx=0, carry=0, sum=0, cout=0, ovf=0, out_valid=0; in_ready=1 once in IDLE.
- States: IDLE, RUN, DONE. All outputs are registered or decoded from state; no input-to-output combinational path.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
  - busy = (state!=IDLE).
- IDLE: on in_valid && in_ready at edge E0:
  - Latch a into a_r.
  - Latch b_eff = sub ? ~b : b into b_r.
  - carry <= sub ? 1 : cin (cin ignored when sub=1).
  - Capture sign operands: a_msb = a[WIDTH-1], b_msb = b_eff[WIDTH-1].
  - idx <= 0; go to RUN.
- RUN: each edge applies slice idx:
  - Slice inputs: A=a_r[4*idx+:4], B=b_r[4*idx+:4], Cin=carry.
  - sum[4*idx+:4] <= slice Sum; carry <= slice Cout; idx <= idx+1.
  - Slice idx==NSLICE-1 (edge E_NSLICE):
    - cout <= slice Cout.
    - ovf <= (a_msb==b_msb) && (slice Sum[3] != a_msb).
    - Go to DONE.
- Latency: out_valid rises exactly NSLICE edges after the accepting edge E0. With WIDTH=4 this is 1 edge.
- DONE: sum/cout/ovf held stable while out_valid=1 && out_ready=0. In DONE, on out_ready=1 go to IDLE at the next edge. Result registers keep their last value in IDLE; no clearing.
- in_valid is ignored whenever in_ready=0. a/b/cin/sub changes after acceptance have no effect.
- No back-to-back accept in DONE; minimum issue interval is NSLICE+2 cycles with out_ready tied high.
- sum bits of slices not yet processed in RUN are don't-care to consumers; valid only when out_valid=1.
- idx counter width = max(1, $clog2(NSLICE)); never exceeds NSLICE-1.
- Reset mid-RUN or mid-DONE aborts the operation; no result is emitted after release.

Decomposition:
- Shared package cla_pkg:
  - Constant SLICE_W = 4.
  - State enum typedef cla_seq_state_t {IDLE, RUN, DONE}.
  - Function for the overflow rule.
- Sub-module: instantiate the team's existing 4-bit carry_lookahead_adder as the single shared slice (ports A, B, Cin, Sum, Cout). Controller, operand/result registers and counter stay in cla_seq_adder.

Test Plan (WIDTH=16, out_ready=1 unless stated):
1. Add, no carry: a=0x1234, b=0x0FFF, cin=0, sub=0 -> sum=0x2233, cout=0, ovf=0; out_valid exactly 4 edges after accept; in_ready low during RUN/DONE.
2. Carry ripple through all slices: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Also a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1.
3. Subtract: a=0x8000, b=0x0001, sub=1, cin=1 (must be ignored) -> sum=0x7FFF, cout=1, ovf=1. Also a=0x0005, b=0x0005, sub=1 -> sum=0x0000, cout=1, ovf=0.
4. Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands -> sum/cout/ovf/out_valid stable, in_ready=0, no new op accepted. Raise out_ready -> IDLE next edge; the pending in_valid is accepted on the following edge.
5. Async reset mid-RUN: assert rst_n=0 after 2 slices, between clock edges -> out_valid=0, sum=0, busy=0 immediately. After release, in_ready=1 and no result is emitted for the aborted op.
6. Input isolation: change a/b/sub on every cycle during RUN after accepting 0x00FF+0x0001 -> sum=0x0100, cout=0.
